regfile_wb_ctrl: RTL
====================

# regfile_wb_ctrl

Write-back controller and scoreboard for the 32-entry register file. It arbitrates the register file's single write port between the ALU and load/store write-back requesters. It registers the winning write onto the `rd_wr_i`/`rd_addr_i`/`rd_data_i` port and tracks pending destination registers in a scoreboard, so the decode stage can stall on RAW and WAW hazards. It sits between the issue/execute stages and the register file, in the same clock domain.

## Interface
- `N`, 32, data width; matches the register file width.
- `ADDR`, 5, register address width.
- `M`, 32, number of registers; equals 2^ADDR.

- `clk_i`  in  1  clock, rising edge.
- `rst_ni`  in  1  reset; synchronous, active-low.
- `iss_valid_i`  in  1  issue stage reserves a destination register.
- `iss_rd_i`  in  ADDR  destination to reserve.
- `iss_ready_o`  out  1  reservation accepted this cycle.
- `rs1_addr_i`, `rs2_addr_i`  in  ADDR  source registers of the instruction in decode.
- `rs1_busy_o`, `rs2_busy_o`  out  1  the source register has a pending write.
- `alu_valid_i`  in  1  ALU write-back request.
- `alu_rd_i`  in  ADDR  ALU write-back destination.
- `alu_data_i`  in  N  ALU write-back data.
- `alu_ready_o`  out  1  ALU request granted.
- `lsu_valid_i`  in  1  load write-back request.
- `lsu_rd_i`  in  ADDR  load write-back destination.
- `lsu_data_i`  in  N  load write-back data.
- `lsu_ready_o`  out  1  load request granted.
- `rf_wr_o`  out  1  register file write enable; drives `rd_wr_i`.
- `rf_addr_o`  out  ADDR  drives `rd_addr_i`.
- `rf_data_o`  out  N  drives `rd_data_i`.
- `busy_o`  out  M  scoreboard vector; bit i means register i has a pending write.

## Operation
- **Scoreboard:** M-bit register `busy`.
  - Bit 0 is hard-wired to 0.
  - `rs1_busy_o = busy[rs1_addr_i]`; `rs2_busy_o = busy[rs2_addr_i]`. Both are combinational.
- **Issue:** `iss_ready_o = rst_ni & ~busy[iss_rd_i]`, which stalls on WAW.
  - Handshake: `iss_valid_i & iss_ready_o`.
  - On handshake, set `busy[iss_rd_i]`. If `iss_rd_i == 0`, accept the handshake and leave the scoreboard unchanged.
- **Arbitration:** at most one grant per cycle.
  - `alu_ready_o` and `lsu_ready_o` are combinational and mutually exclusive.
  - Both are 0 while `rst_ni` is low.
  - A single valid requester is always granted.
  - When both are valid, the policy is set under Configuration.
- **Write stage:** on a granted request, at the next edge:
  - `rf_wr_o <= (rd != 0)`
  - `rf_addr_o <= rd`
  - `rf_data_o <= data`

  With no grant, `rf_wr_o <= 0` and `rf_addr_o`/`rf_data_o` hold their values.
- **Write to x0:** the handshake completes and the data is discarded; `rf_wr_o` stays 0.
- **Clear:** in a cycle with `rf_wr_o == 1`, clear `busy[rf_addr_o]` at the end of the cycle, on the same edge the register file captures the write.
- **Simultaneous set and clear of the same register:** set wins, because the new reservation supersedes the completing write.
- **Write-back to a non-busy register:** the write is performed; the clear is a no-op; there is no error.
- **Reset values:**
  - `busy = 0`
  - `rf_wr_o = 0`, `rf_addr_o = 0`, `rf_data_o = 0`
  - round-robin pointer = "LSU last granted", so the ALU wins the first conflict
- **Reset mid-operation:** the next edge with `rst_ni` low discards any pending write (`rf_wr_o` goes to 0) and clears all scoreboard bits. No request is granted during reset.

## Timing
- Grant latency: 0 cycles. Ready is asserted in the same cycle as valid when the requester wins.
- Write latency: handshake in cycle T, then `rf_wr_o` high in T+1 for exactly one cycle, then the register file is updated at the end of T+1.
- Scoreboard:
  - Busy bit visible in T+1 after an issue handshake in T.
  - Busy bit cleared in T+2 after a write-back handshake in T.
- Throughput: one write-back per cycle. The loser of a conflict waits at least one cycle.
- Requesters must hold valid, rd and data stable until ready.

## Configuration
- `RR_ARB_EN` defined:
  - Round-robin arbitration.
  - On a conflict, grant the requester not granted most recently.
  - The pointer updates on every grant, including grants to x0.
- `RR_ARB_EN` undefined:
  - Fixed priority; the LSU always wins a conflict.
  - No pointer state exists.
  - The ALU can starve while `lsu_valid_i` stays high.

## Test plan
- **Reset:** hold `rst_ni = 0` for 2 cycles with all valids high -> `busy_o = 0`, `rf_wr_o = 0`, both readies 0, `iss_ready_o = 0`.
- **Issue/write-back round trip:**
  - Issue rd = 5 in cycle 1 -> `busy_o[5] = 1` and `rs1_busy_o = 1` for `rs1_addr_i = 5` from cycle 2.
  - ALU writes rd = 5, data 0xDEADBEEF in cycle 3 -> cycle 4: `rf_wr_o = 1`, `rf_addr_o = 5`, `rf_data_o = 0xDEADBEEF` -> cycle 5: `busy_o[5] = 0`.
- **WAW stall:** with `busy[7] = 1`, `iss_rd_i = 7` -> `iss_ready_o = 0` until the cycle after the write to 7 completes.
- **Conflict:** ALU (rd = 1) and LSU (rd = 2) valid together for 4 cycles.
  - With `RR_ARB_EN`: grants go ALU, LSU, ALU, LSU.
  - Without it: LSU in all 4 cycles.
- **x0:** LSU write-back rd = 0, data 0x1234 -> `lsu_ready_o = 1`, next cycle `rf_wr_o = 0`; an issue with rd = 0 leaves `busy_o = 0`.
- **Set/clear collision and mid-operation reset:**
  - Issue rd = 3 in the same cycle that `rf_wr_o = 1`, `rf_addr_o = 3` -> `busy_o[3]` remains 1.
  - Then assert `rst_ni = 0` with a write-back granted in the previous cycle -> `rf_wr_o = 0` after the edge and `busy_o = 0`.

Source files
------------

// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: write-back arbiter and pending-write scoreboard for the
// 32-entry register file.
//
// The ALU and LSU compete for the register file's single write port. The
// winning request is registered onto rf_wr_o/rf_addr_o/rf_data_o one cycle
// after its handshake. A scoreboard holds one bit per register, so decode can
// stall on RAW hazards (rs*_busy_o) and issue can stall on WAW hazards
// (iss_ready_o).
//
// Optional feature macro: RR_ARB_EN
//   defined   : round-robin arbitration between ALU and LSU
//   undefined : fixed priority, where the LSU always wins a conflict
//
// Ports:
//   clk_i, rst_ni          clock (rising edge), synchronous active-low reset
//   iss_valid_i/iss_rd_i   issue reserves a destination; iss_ready_o accepts
//   rs1/rs2_addr_i         decode sources; rs1/rs2_busy_o flag pending writes
//   alu_valid/rd/data_i    ALU write-back request; alu_ready_o is its grant
//   lsu_valid/rd/data_i    load write-back request; lsu_ready_o is its grant
//   rf_wr_o/addr_o/data_o  registered register-file write port
//   busy_o                 scoreboard vector (bit 0 is always 0)
module regfile_wb_ctrl #(
    parameter int N    = 32,
    parameter int ADDR = 5,
    parameter int M    = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            iss_valid_i,
    input  logic [ADDR-1:0] iss_rd_i,
    output logic            iss_ready_o,
    input  logic [ADDR-1:0] rs1_addr_i,
    input  logic [ADDR-1:0] rs2_addr_i,
    output logic            rs1_busy_o,
    output logic            rs2_busy_o,
    input  logic            alu_valid_i,
    input  logic [ADDR-1:0] alu_rd_i,
    input  logic [N-1:0]    alu_data_i,
    output logic            alu_ready_o,
    input  logic            lsu_valid_i,
    input  logic [ADDR-1:0] lsu_rd_i,
    input  logic [N-1:0]    lsu_data_i,
    output logic            lsu_ready_o,
    output logic            rf_wr_o,
    output logic [ADDR-1:0] rf_addr_o,
    output logic [N-1:0]    rf_data_o,
    output logic [M-1:0]    busy_o
);

    logic [M-1:0]    busy_q, busy_d;
    logic            rf_wr_q, rf_wr_d;
    logic [ADDR-1:0] rf_addr_q, rf_addr_d;
    logic [N-1:0]    rf_data_q, rf_data_d;
    logic            alu_gnt, lsu_gnt, iss_hs;

`ifdef RR_ARB_EN
    // lsu_last_q is 1 when the LSU was granted most recently. It resets to 1
    // so that the ALU wins the first conflict.
    logic lsu_last_q, lsu_last_d;

    assign alu_gnt    = rst_ni & alu_valid_i & (~lsu_valid_i | lsu_last_q);
    assign lsu_gnt    = rst_ni & lsu_valid_i & ~(alu_valid_i & lsu_last_q);
    assign lsu_last_d = lsu_gnt ? 1'b1 : (alu_gnt ? 1'b0 : lsu_last_q);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) lsu_last_q <= 1'b1;
        else         lsu_last_q <= lsu_last_d;
    end
`else
    assign alu_gnt = rst_ni & alu_valid_i & ~lsu_valid_i;
    assign lsu_gnt = rst_ni & lsu_valid_i;
`endif

    assign alu_ready_o = alu_gnt;
    assign lsu_ready_o = lsu_gnt;

    assign iss_ready_o = rst_ni & ~busy_q[iss_rd_i];
    assign iss_hs      = iss_valid_i & iss_ready_o;
    assign rs1_busy_o  = busy_q[rs1_addr_i];
    assign rs2_busy_o  = busy_q[rs2_addr_i];
    assign busy_o      = busy_q;

    assign rf_wr_o   = rf_wr_q;
    assign rf_addr_o = rf_addr_q;
    assign rf_data_o = rf_data_q;

    // Address and data hold their values when nothing is granted. A grant to
    // x0 completes its handshake but never raises the write enable.
    always_comb begin
        rf_addr_d = lsu_gnt ? lsu_rd_i   : (alu_gnt ? alu_rd_i   : rf_addr_q);
        rf_data_d = lsu_gnt ? lsu_data_i : (alu_gnt ? alu_data_i : rf_data_q);
        rf_wr_d   = (alu_gnt | lsu_gnt) & (rf_addr_d != '0);
    end

    // The clear is applied before the set, so a new reservation of the
    // register being written this cycle survives.
    always_comb begin
        busy_d = busy_q;
        if (rf_wr_q) busy_d[rf_addr_q] = 1'b0;
        if (iss_hs)  busy_d[iss_rd_i]  = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            busy_q    <= '0;
            rf_wr_q   <= 1'b0;
            rf_addr_q <= '0;
            rf_data_q <= '0;
        end else begin
            busy_q    <= busy_d;
            rf_wr_q   <= rf_wr_d;
            rf_addr_q <= rf_addr_d;
            rf_data_q <= rf_data_d;
        end
    end

endmodule
